// File: rtl/temporal_spike_encoder.sv
// Temporal spike encoder: turns one frame of intensities into a time-to-first-spike volley.
// Optional early termination on downstream inhibit is compiled in with EARLY_STOP_EN.
module temporal_spike_encoder #(
   parameter int NUM_INPUTS  = 16,
   parameter int TIME_PERIOD = 8,
   parameter int TW          = $clog2(TIME_PERIOD)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_INPUTS*TW-1:0] in_data,
   input  logic                     inhibit,
   output logic [TW-1:0]            time_val,
   output logic [NUM_INPUTS-1:0]    spike_volley,
   output logic                     volley_active,
   output logic                     volley_start,
   output logic                     volley_done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [TW-1:0] LAST_T = TW'(TIME_PERIOD - 1);

   state_t                  state_q;
   logic [TW-1:0]           cnt_q;
   logic [TW-1:0]           cnt_d;
   logic [NUM_INPUTS*TW-1:0] data_q;
   logic [TW-1:0]           time_q;
   logic [NUM_INPUTS-1:0]   spike_q;
   logic                    active_q;
   logic                    start_q;
   logic                    done_q;
   logic                    stopNow;

   // Larger intensity fires earlier: value v fires at t = TIME_PERIOD-1 - v.
   function automatic logic [NUM_INPUTS-1:0] spikesAt(
      input logic [NUM_INPUTS*TW-1:0] vals,
      input logic [TW-1:0]            t
   );
      logic [NUM_INPUTS-1:0] s;
      s = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         s[i] = (t == LAST_T - vals[i*TW +: TW]);
      end
      return s;
   endfunction

   assign cnt_d = cnt_q + TW'(1);

`ifdef EARLY_STOP_EN
   assign stopNow = (cnt_q == LAST_T) || inhibit;
`else
   logic unusedInhibit;
   assign unusedInhibit = inhibit;
   assign stopNow       = (cnt_q == LAST_T);
`endif

   assign in_ready = (state_q == IDLE) && !rst;

   // Outputs are precomputed one cycle ahead so every visible output is a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         data_q   <= '0;
         time_q   <= '0;
         spike_q  <= '0;
         active_q <= 1'b0;
         start_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         time_q   <= '0;
         spike_q  <= '0;
         active_q <= 1'b0;
         start_q  <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  data_q   <= in_data;
                  cnt_q    <= '0;
                  state_q  <= RUN;
                  active_q <= 1'b1;
                  start_q  <= 1'b1;
                  spike_q  <= spikesAt(in_data, TW'(0));
               end
            end
            RUN: begin
               if (stopNow) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q    <= cnt_d;
                  time_q   <= cnt_d;
                  active_q <= 1'b1;
                  spike_q  <= spikesAt(data_q, cnt_d);
               end
            end
            DONE: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign time_val      = time_q;
   assign spike_volley  = spike_q;
   assign volley_active = active_q;
   assign volley_start  = start_q;
   assign volley_done   = done_q;

endmodule

// File: tb/tb_temporal_spike_encoder.sv
// Self-checking bench for temporal_spike_encoder (4 inputs, 8-step window).
// A directed table, hand-written corner sequences and random traffic are checked against a frame-level model.
module tb_temporal_spike_encoder;

   localparam int NI = 4;
   localparam int TP = 8;
   localparam int TWB = 3;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [NI*TWB-1:0] in_data;
   logic              inhibit;
   logic [TWB-1:0]    time_val;
   logic [NI-1:0]     spike_volley;
   logic              volley_active;
   logic              volley_start;
   logic              volley_done;

   int checks;
   int errors;

   // Frame-level model: cycles since acceptance and the last t the window reaches.
   bit mBusy;
   int mRel;
   int mStop;
   int mVals[NI];

   typedef struct {
      logic              r;
      logic              v;
      logic [NI*TWB-1:0] d;
      logic              inh;
      logic              eReady;
      logic [TWB-1:0]    eTime;
      logic [NI-1:0]     eSpike;
      logic              eAct;
      logic              eStart;
      logic              eDone;
   } vec_t;

   vec_t tbl[11];

   temporal_spike_encoder #(
      .NUM_INPUTS (NI),
      .TIME_PERIOD(TP),
      .TW         (TWB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .inhibit      (inhibit),
      .time_val     (time_val),
      .spike_volley (spike_volley),
      .volley_active(volley_active),
      .volley_start (volley_start),
      .volley_done  (volley_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic r, input logic v, input logic [NI*TWB-1:0] d, input logic inh);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      in_data  = d;
      inhibit  = inh;
      #1;
   endtask

   task automatic cmp(input string name, input string field, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s.%s: got %0h expected %0h at %0t", name, field, got, exp, $time);
      end
   endtask

   task automatic checkOutput(input string name, input logic eReady, input logic [TWB-1:0] eTime,
                              input logic [NI-1:0] eSpike, input logic eAct, input logic eStart,
                              input logic eDone);
      cmp(name, "in_ready", 8'(in_ready), 8'(eReady));
      cmp(name, "time_val", 8'(time_val), 8'(eTime));
      cmp(name, "spike_volley", 8'(spike_volley), 8'(eSpike));
      cmp(name, "volley_active", 8'(volley_active), 8'(eAct));
      cmp(name, "volley_start", 8'(volley_start), 8'(eStart));
      cmp(name, "volley_done", 8'(volley_done), 8'(eDone));
   endtask

   task automatic modelCheck(input string name);
      logic           eReady;
      logic [TWB-1:0] eTime;
      logic [NI-1:0]  eSpike;
      logic           eAct;
      logic           eStart;
      logic           eDone;
      int             t;
      eReady = 1'b0;
      eTime  = '0;
      eSpike = '0;
      eAct   = 1'b0;
      eStart = 1'b0;
      eDone  = 1'b0;
      if (!mBusy) begin
         eReady = !rst;
      end else begin
         t = mRel - 1;
         if (t <= mStop) begin
            eTime  = TWB'(t);
            eAct   = 1'b1;
            eStart = (t == 0);
            for (int i = 0; i < NI; i++) eSpike[i] = (mVals[i] + t == TP - 1);
         end else begin
            eDone = 1'b1;
         end
      end
      checkOutput(name, eReady, eTime, eSpike, eAct, eStart, eDone);
   endtask

   task automatic modelAdvance(input logic r, input logic v, input logic [NI*TWB-1:0] d, input logic inh);
      int t;
      bit useInh;
`ifdef EARLY_STOP_EN
      useInh = 1'b1;
`else
      useInh = 1'b0;
`endif
      if (r) begin
         mBusy = 1'b0;
      end else if (!mBusy) begin
         if (v) begin
            mBusy = 1'b1;
            mRel  = 1;
            mStop = TP - 1;
            for (int i = 0; i < NI; i++) mVals[i] = int'(d[i*TWB +: TWB]);
         end
      end else begin
         t = mRel - 1;
         if (t <= mStop) begin
            if (useInh && inh && t < mStop) mStop = t;
            mRel++;
         end else begin
            mBusy = 1'b0;
         end
      end
   endtask

   task automatic step(input string name, input logic r, input logic v, input logic [NI*TWB-1:0] d, input logic inh);
      applyStimulus(r, v, d, inh);
      modelCheck(name);
      modelAdvance(r, v, d, inh);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      mBusy    = 1'b0;
      mRel     = 0;
      mStop    = TP - 1;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      inhibit  = 1'b0;

      // Frame {7,0,3,5}: input0 at t=0, input3 at t=2, input2 at t=4, input1 at t=7.
      tbl[0]  = '{1'b0, 1'b1, 12'hAC7, 1'b0, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 4'b0001, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd1, 4'b0000, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd2, 4'b1000, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd3, 4'b0000, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd4, 4'b0100, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd5, 4'b0000, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd6, 4'b0000, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd7, 4'b0010, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0};

      @(posedge clk);
      step("reset", 1'b1, 1'b0, 12'h000, 1'b0);
      step("rstvalid", 1'b1, 1'b1, 12'hFFF, 1'b0);
      step("postreset", 1'b0, 1'b0, 12'h000, 1'b0);

      $display("[TB] basic encode table");
      for (int i = 0; i < 11; i++) begin
         applyStimulus(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].inh);
         checkOutput($sformatf("basic%0d", i), tbl[i].eReady, tbl[i].eTime, tbl[i].eSpike,
                     tbl[i].eAct, tbl[i].eStart, tbl[i].eDone);
         modelAdvance(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].inh);
      end

      $display("[TB] back-to-back with held-off data");
      step("b2b_acc", 1'b0, 1'b1, 12'hAC7, 1'b0);
      for (int i = 0; i < 9; i++) step($sformatf("b2b_run%0d", i), 1'b0, 1'b1, 12'h1B5, 1'b0);
      step("b2b_acc2", 1'b0, 1'b1, 12'h1B5, 1'b0);
      for (int i = 0; i < 11; i++) step($sformatf("b2b_tail%0d", i), 1'b0, 1'b0, 12'h000, 1'b0);

      $display("[TB] simultaneous spikes");
      step("sim_acc", 1'b0, 1'b1, 12'h924, 1'b0);
      for (int i = 0; i < 11; i++) step($sformatf("sim%0d", i), 1'b0, 1'b0, 12'h000, 1'b0);

      $display("[TB] mid-run reset");
      step("mr_acc", 1'b0, 1'b1, 12'hAC7, 1'b0);
      for (int i = 0; i < 3; i++) step($sformatf("mr_run%0d", i), 1'b0, 1'b0, 12'h000, 1'b0);
      step("mr_rst", 1'b1, 1'b0, 12'h000, 1'b0);
      step("mr_after", 1'b0, 1'b0, 12'h000, 1'b0);
      step("mr_acc2", 1'b0, 1'b1, 12'h5F2, 1'b0);
      for (int i = 0; i < 11; i++) step($sformatf("mr_tail%0d", i), 1'b0, 1'b0, 12'h000, 1'b0);

      $display("[TB] inhibit at t=2");
      step("es_acc", 1'b0, 1'b1, 12'hAC7, 1'b0);
      step("es_t0", 1'b0, 1'b0, 12'h000, 1'b0);
      step("es_t1", 1'b0, 1'b0, 12'h000, 1'b0);
      step("es_t2", 1'b0, 1'b0, 12'h000, 1'b1);
      for (int i = 0; i < 9; i++) step($sformatf("es_tail%0d", i), 1'b0, 1'b0, 12'h000, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         step($sformatf("rnd%0d", i), ($urandom_range(0, 40) == 0), ($urandom_range(0, 2) != 0),
              12'($urandom), ($urandom_range(0, 5) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/temporal_spike_encoder.md
# temporal_spike_encoder

- Converts one frame of input intensities into a temporally coded spike volley over a window of `TIME_PERIOD` time steps.
- Each input fires exactly once: larger values fire earlier.
- Sits upstream of the excitatory neuron layer and the winner-take-all inhibition stage. It supplies the spike volley and the shared `time_val` they consume.
- It also signals window start and end so downstream inhibition state can be cleared between frames.

## Interface
- `NUM_INPUTS`, 16, number of encoded inputs (spike lines).
- `TIME_PERIOD`, 8, time steps per window; power of two, ≥2.
- `TW`, `$clog2(TIME_PERIOD)`, width of a value and of `time_val`.

Ports (direction, width, meaning):
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  frame present on `in_data`.
- `in_ready`  out  1  encoder can accept a frame.
- `in_data`  in  NUM_INPUTS*TW  intensities; value i at bits [i*TW +: TW].
- `inhibit`  in  1  downstream winner found; used only with `EARLY_STOP_EN`, ignored otherwise.
- `time_val`  out  TW  current time step of the window.
- `spike_volley`  out  NUM_INPUTS  one-cycle spike per input.
- `volley_active`  out  1  high during every RUN cycle.
- `volley_start`  out  1  pulse in first RUN cycle (t=0).
- `volley_done`  out  1  pulse in the DONE cycle.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: capture `in_data`, clear counter, go to RUN.
  - All other outputs 0.
- **RUN**
  - `time_val` = counter t, which increments each cycle.
  - `spike_volley[i]` = (t == TIME_PERIOD-1 - value[i]), so value TIME_PERIOD-1 fires at t=0 and value 0 fires at t=TIME_PERIOD-1.
  - At t=TIME_PERIOD-1, go to DONE. Counter does not wrap inside RUN.
- **DONE**
  - `volley_done`=1, `spike_volley`=0, `time_val`=0.
  - Go to IDLE unconditionally.
- Output decoding:
  - All outputs decode from registered state, counter and captured data only. There is no combinational path from inputs to outputs.
  - Exception: `in_ready`, which is (state==IDLE) && !rst.
- Frame handling:
  - Captured data is held for the whole window.
  - `in_valid` is ignored outside IDLE; the source holds its frame until accepted.
- Arithmetic: spike compare is TW-bit unsigned. Every input fires exactly once per full window, and multiple inputs may fire in the same cycle.

## Timing
- Reset values (registered, cycle after `rst` seen high): state IDLE, counter 0, captured data 0. `time_val`, `spike_volley`, `volley_active`, `volley_start` and `volley_done` are all 0.
- `in_ready`=0 while `rst`=1 and 1 in the first cycle with `rst`=0.
- Latency for a handshake in cycle k:
  - RUN t=0 (`volley_start`) in k+1.
  - t=TIME_PERIOD-1 in k+TIME_PERIOD.
  - DONE in k+TIME_PERIOD+1.
  - IDLE in k+TIME_PERIOD+2.
- Maximum frame rate: one frame per TIME_PERIOD+2 cycles.
- Reset during RUN or DONE: next cycle IDLE with all outputs 0. No `volley_done` is emitted and the captured frame is discarded.
- Simultaneous `rst` and `in_valid`: reset wins and the frame is not accepted.

## Configuration
- Macro: `EARLY_STOP_EN`.
- **Defined:**
  - `inhibit` is sampled in RUN. If high in the cycle with counter t, that cycle's spikes are still emitted and the next cycle is DONE.
  - Remaining spikes are suppressed.
  - `inhibit` outside RUN has no effect.
  - `inhibit` at t=TIME_PERIOD-1 behaves as normal completion.
- **Undefined:** `inhibit` is ignored and every window runs the full TIME_PERIOD cycles.

## Test plan
All scenarios use TIME_PERIOD=8, NUM_INPUTS=4, accept cycle k.
- **Basic encode.** Load values {7,0,3,5} (input0..3).
  - Spikes: input0 at t=0, input3 at t=2, input2 at t=4, input1 at t=7, each exactly one cycle.
  - `volley_start` at k+1, `volley_done` at k+9, `in_ready` high again at k+10.
- **Back-to-back.** `in_valid` held with two frames: second accepted at k+10, its `volley_start` at k+11, and no spike lines high in k+9 or k+10.
- **Simultaneous spikes.** All values 4: `spike_volley`=4'b1111 only at t=3 and 0 in all other cycles.
- **Mid-run reset.** `rst` pulsed one cycle at t=3:
  - Next cycle all outputs 0, with no `volley_done`.
  - `in_ready`=1 the cycle after `rst` deasserts.
  - A new frame then runs a full window.
- **Early stop.**
  - With `EARLY_STOP_EN`: `inhibit` high at t=2 on frame {7,0,3,5} gives spikes at t=0 and t=2 only, DONE next cycle, and `volley_done` at k+4.
  - Without `EARLY_STOP_EN`: the same stimulus gives all four spikes and `volley_done` at k+9.
- **Held-off input.** `in_valid` asserted with different data during RUN: not captured, and the current window's spikes match the first frame exactly.
